// File: rtl/mainbus_pkg.sv
// Shared definitions for the main-bus memory controller: default sizes,
// the page-ID width and the controller state encoding.
package mainbus_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int OFFSET_W_DEF  = 12;
    localparam int BURST_LEN_DEF = 4;
    localparam int PAGE_W        = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } mbc_state_t;

endpackage

// File: rtl/mainbus_if.sv
// Main-bus signals as seen between the processor (master) and a memory
// controller (slave). addrData is split into the in/out halves plus an
// output-enable, so the interface itself stays free of tristates.
interface mainbus_if #(
    parameter int DATA_W = 16
) ();

    logic              addrValid;
    logic              rw;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              busy;

    modport master (
        output addrValid,
        output rw,
        output bus_in,
        input  bus_out,
        input  bus_oe,
        input  busy
    );

    modport slave (
        input  addrValid,
        input  rw,
        input  bus_in,
        output bus_out,
        output bus_oe,
        output busy
    );

endinterface

// File: rtl/mainbus_mem_array.sv
// Single-port word array: synchronous write, registered read.
// Contents are never cleared; a read in the same cycle as a write to the
// same word returns the old contents.
module mainbus_mem_array #(
    parameter int DATA_W   = 16,
    parameter int OFFSET_W = 12
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [OFFSET_W-1:0] addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int DEPTH = 2 ** OFFSET_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port share the one address.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mainbus_mem_ctrl.sv
// Main-bus memory controller, one instance per page. Accepts an address
// phase whose top nibble matches PAGE_ID, then streams a fixed burst of
// words out of (READ) or into (WRITE) the local array. The read address
// always runs one beat ahead so the registered array output lines up
// with each beat without bubbles.
module mainbus_mem_ctrl
    import mainbus_pkg::*;
#(
    parameter int               DATA_W    = DATA_W_DEF,
    parameter logic [PAGE_W-1:0] PAGE_ID  = 4'h2,
    parameter int               OFFSET_W  = OFFSET_W_DEF,
    parameter int               BURST_LEN = BURST_LEN_DEF
) (
    input logic      clk,
    input logic      resetN,
    mainbus_if.slave bus
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    mbc_state_t          state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [OFFSET_W-1:0] base_q, base_d;

    logic                mem_we;
    logic [OFFSET_W-1:0] mem_addr;
    logic [DATA_W-1:0]   mem_rdata;

    logic                page_hit;
    logic                last_beat;

    assign page_hit  = bus.addrValid && (bus.bus_in[DATA_W-1 -: PAGE_W] == PAGE_ID);
    assign last_beat = (beat_q == LAST_BEAT);

    // Control state: state and beat count are reset, the base offset is data.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
        base_q <= base_d;
    end

    // Next-state, beat advance and array address/write-enable generation.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        base_d   = base_q;
        mem_we   = 1'b0;
        mem_addr = bus.bus_in[OFFSET_W-1:0];

        case (state_q)
            IDLE: begin
                // Base is presented to the array now so beat 0 is ready at T+1.
                if (page_hit) begin
                    base_d  = bus.bus_in[OFFSET_W-1:0];
                    beat_d  = '0;
                    state_d = bus.rw ? READ : WRITE;
                end
            end
            READ: begin
                // Prefetch the word for the following beat; offset wraps naturally.
                mem_addr = base_q + OFFSET_W'(beat_q) + OFFSET_W'(1);
                beat_d   = beat_q + BEAT_W'(1);
                if (last_beat) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                // A reset arriving mid-burst must suppress the write of this beat.
                mem_addr = base_q + OFFSET_W'(beat_q);
                mem_we   = resetN;
                beat_d   = beat_q + BEAT_W'(1);
                if (last_beat) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    mainbus_mem_array #(
        .DATA_W  (DATA_W),
        .OFFSET_W(OFFSET_W)
    ) u_array (
        .clk_i  (clk),
        .we_i   (mem_we),
        .addr_i (mem_addr),
        .wdata_i(bus.bus_in),
        .rdata_o(mem_rdata)
    );

    assign bus.bus_oe  = (state_q == READ);
    assign bus.busy    = (state_q != IDLE);
    assign bus.bus_out = bus.bus_oe ? mem_rdata : '0;

endmodule

// File: tb/tb_mainbus_mem_ctrl.sv
// Directed bench for the main-bus memory controller.
module tb_mainbus_mem_ctrl;

    logic clk;
    logic resetN;

    int n_checks;
    int n_pass;

    mainbus_if #(.DATA_W(16)) bus ();

    mainbus_mem_ctrl #(
        .DATA_W   (16),
        .PAGE_ID  (4'h2),
        .OFFSET_W (12),
        .BURST_LEN(4)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_oe"},   16'(bus.bus_oe), 16'd0);
        check({tag, "_busy"}, 16'(bus.busy),   16'd0);
        check({tag, "_out"},  bus.bus_out,     16'd0);
    endtask

    // Write burst: addr phase now, data words w[15:0], w[31:16], ... on beats.
    task automatic write_burst(input logic [15:0] addr, input logic [63:0] w);
        bus.addrValid = 1'b1;
        bus.rw        = 1'b0;
        bus.bus_in    = addr;
        tick();
        bus.addrValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.bus_in = w[i*16 +: 16];
            check($sformatf("wr_busy%0d", i), 16'(bus.busy),   16'd1);
            check($sformatf("wr_oe%0d", i),   16'(bus.bus_oe), 16'd0);
            tick();
        end
        bus.bus_in = 16'h0000;
    endtask

    // Read burst; beats whose mask bit is clear are not compared.
    task automatic read_burst(input logic [15:0] addr, input logic [63:0] w, input logic [3:0] mask);
        bus.addrValid = 1'b1;
        bus.rw        = 1'b1;
        bus.bus_in    = addr;
        check("rd_T_oe", 16'(bus.bus_oe), 16'd0);
        tick();
        bus.addrValid = 1'b0;
        bus.bus_in    = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd_oe%0d", i),   16'(bus.bus_oe), 16'd1);
            check($sformatf("rd_busy%0d", i), 16'(bus.busy),   16'd1);
            if (mask[i]) check($sformatf("rd_data%0d", i), bus.bus_out, w[i*16 +: 16]);
            tick();
        end
        check_idle("rd_end");
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        resetN        = 1'b0;
        bus.addrValid = 1'b0;
        bus.rw        = 1'b0;
        bus.bus_in    = 16'h0000;
        repeat (3) tick();
        check_idle("reset");
        resetN = 1'b1;
        tick();
        check_idle("idle");

        // 1: write then read
        write_burst(16'h2010, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0});
        check_idle("wr1_end");
        read_burst(16'h2010, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 4'b1111);

        // 2: offset wrap within the page
        write_burst(16'h2FFE, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
        read_burst(16'h2000, {16'h0000, 16'h0000, 16'h0004, 16'h0003}, 4'b0011);
        read_burst(16'h2FFE, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4'b1111);

        // 3: foreign page is ignored (would-be write data would clobber 0x010..)
        bus.addrValid = 1'b1;
        bus.rw        = 1'b0;
        bus.bus_in    = 16'h3010;
        tick();
        bus.addrValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.bus_in = 16'h5550 + 16'(i);
            check($sformatf("foreign_busy%0d", i), 16'(bus.busy),   16'd0);
            check($sformatf("foreign_oe%0d", i),   16'(bus.bus_oe), 16'd0);
            tick();
        end
        bus.bus_in = 16'h0000;
        read_burst(16'h2010, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 4'b1111);

        // 4: back-to-back; address phase on the last beat is ignored
        bus.addrValid = 1'b1;
        bus.rw        = 1'b1;
        bus.bus_in    = 16'h2010;
        tick();
        bus.addrValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_data%0d", i), bus.bus_out, 16'h00A0 + 16'(i));
            if (i == 3) begin
                bus.addrValid = 1'b1;
                bus.rw        = 1'b0;
                bus.bus_in    = 16'h2FFE;
            end
            tick();
        end
        check("b2b_T5_busy", 16'(bus.busy), 16'd0);
        bus.addrValid = 1'b1;
        bus.rw        = 1'b1;
        bus.bus_in    = 16'h2FFE;
        tick();
        bus.addrValid = 1'b0;
        bus.bus_in    = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b2_oe%0d", i),   16'(bus.bus_oe), 16'd1);
            check($sformatf("b2b2_data%0d", i), bus.bus_out, 16'd1 + 16'(i));
            tick();
        end
        check_idle("b2b2_end");

        // 5: reset during read beat 2
        bus.addrValid = 1'b1;
        bus.rw        = 1'b1;
        bus.bus_in    = 16'h2010;
        tick();
        bus.addrValid = 1'b0;
        tick();
        tick();
        check("rst_rd_beat2", bus.bus_out, 16'h00A2);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        check_idle("rst_rd_after");
        read_burst(16'h2010, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 4'b1111);

        // 6: reset during write beat 2; only beats 0 and 1 land
        bus.addrValid = 1'b1;
        bus.rw        = 1'b0;
        bus.bus_in    = 16'h2010;
        tick();
        bus.addrValid = 1'b0;
        bus.bus_in    = 16'h00B0;
        tick();
        bus.bus_in    = 16'h00B1;
        tick();
        bus.bus_in    = 16'h00B2;
        resetN        = 1'b0;
        tick();
        resetN        = 1'b1;
        bus.bus_in    = 16'h00B3;
        check("rst_wr_busy", 16'(bus.busy), 16'd0);
        tick();
        bus.bus_in    = 16'h0000;
        read_burst(16'h2010, {16'h00A3, 16'h00A2, 16'h00B1, 16'h00B0}, 4'b1111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
